// File: rtl/prng_arbiter.sv
// Seeds and free-runs an external 16-bit LCG, and hands fresh values to two round-robin requesters.
// Optional define PRNG_ARBITER_SEED_MIX_EN XORs captured SeedIn values with a free-running counter.
module prng_arbiter #(
   parameter int unsigned STIR_CYCLES = 3,
   parameter logic [9:0]  RESET_SEED  = 10'h000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [9:0]  SeedIn,
   input  logic        SeedLoad,
   input  logic        Req0,
   input  logic        Req1,
   output logic        Ack0,
   output logic        Ack1,
   output logic [15:0] RandOut,
   output logic        Busy,
   output logic        PrngEnable,
   output logic [9:0]  PrngSeed,
   input  logic [15:0] PrngState
);

   typedef enum logic [1:0] {
      ST_SEED = 2'd0,
      ST_RUN  = 2'd1,
      ST_STIR = 2'd2
   } state_t;

   localparam logic [3:0] STIR_LOAD = 4'(STIR_CYCLES - 1);

   state_t     state_reg;
   logic [9:0] seed_reg;
   logic [9:0] pend_val_reg;
   logic       pend_reg;
   logic       rr_reg;
   logic       grantee_reg;
   logic [3:0] cnt_reg;
   logic [9:0] seed_in_mixed;
   logic       elig0;
   logic       elig1;
   logic       pick1;

`ifdef PRNG_ARBITER_SEED_MIX_EN
   logic [9:0] mix_cnt_reg;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         mix_cnt_reg <= '0;
      end else begin
         mix_cnt_reg <= mix_cnt_reg + 10'd1;
      end
   end

   assign seed_in_mixed = SeedIn ^ mix_cnt_reg;
`else
   assign seed_in_mixed = SeedIn;
`endif

   // A requester being acked this cycle is not eligible, so a late-dropping Req is not served twice.
   assign elig0 = Req0 & ~Ack0;
   assign elig1 = Req1 & ~Ack1;
   assign pick1 = elig1 & (~elig0 | rr_reg);

   assign PrngSeed = seed_reg;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_reg    <= ST_SEED;
         seed_reg     <= RESET_SEED;
         pend_val_reg <= '0;
         pend_reg     <= 1'b0;
         rr_reg       <= 1'b0;
         grantee_reg  <= 1'b0;
         cnt_reg      <= '0;
         Ack0         <= 1'b0;
         Ack1         <= 1'b0;
         RandOut      <= '0;
         Busy         <= 1'b1;
         PrngEnable   <= 1'b0;
      end else begin
         Ack0 <= 1'b0;
         Ack1 <= 1'b0;
         case (state_reg)
            ST_SEED: begin
               if (SeedLoad) begin
                  pend_reg     <= 1'b1;
                  pend_val_reg <= seed_in_mixed;
               end
               PrngEnable <= 1'b1;
               Busy       <= 1'b0;
               state_reg  <= ST_RUN;
            end
            ST_RUN: begin
               if (SeedLoad || pend_reg) begin
                  // A direct pulse is newer than anything pended, so it wins.
                  seed_reg   <= SeedLoad ? seed_in_mixed : pend_val_reg;
                  pend_reg   <= 1'b0;
                  PrngEnable <= 1'b0;
                  Busy       <= 1'b1;
                  state_reg  <= ST_SEED;
               end else if (elig0 || elig1) begin
                  grantee_reg <= pick1;
                  cnt_reg     <= STIR_LOAD;
                  Busy        <= 1'b1;
                  state_reg   <= ST_STIR;
               end
            end
            ST_STIR: begin
               if (SeedLoad) begin
                  pend_reg     <= 1'b1;
                  pend_val_reg <= seed_in_mixed;
               end
               if (cnt_reg == 4'd0) begin
                  RandOut   <= PrngState;
                  Ack0      <= ~grantee_reg;
                  Ack1      <= grantee_reg;
                  rr_reg    <= ~grantee_reg;
                  Busy      <= 1'b0;
                  state_reg <= ST_RUN;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            default: begin
               PrngEnable <= 1'b0;
               Busy       <= 1'b1;
               state_reg  <= ST_SEED;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prng_arbiter.sv
// Directed bench for prng_arbiter with a behavioural LCG standing in for the generator.
// Define PRNG_ARBITER_SEED_MIX_EN to exercise the seed-mixing build instead of the seed-value tests.
module tb_prng_arbiter;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [9:0]  SeedIn = '0;
   logic        SeedLoad = 1'b0;
   logic        Req0 = 1'b0;
   logic        Req1 = 1'b0;
   logic        Ack0;
   logic        Ack1;
   logic [15:0] RandOut;
   logic        Busy;
   logic        PrngEnable;
   logic [9:0]  PrngSeed;
   logic [15:0] gen = '0;

   int checks = 0;
   int failures = 0;

   prng_arbiter #(.STIR_CYCLES(3), .RESET_SEED(10'h000)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .SeedIn    (SeedIn),
      .SeedLoad  (SeedLoad),
      .Req0      (Req0),
      .Req1      (Req1),
      .Ack0      (Ack0),
      .Ack1      (Ack1),
      .RandOut   (RandOut),
      .Busy      (Busy),
      .PrngEnable(PrngEnable),
      .PrngSeed  (PrngSeed),
      .PrngState (gen)
   );

   always #5 Clock = ~Clock;

   // Generator model: loads the seed while disabled, steps state*5+1 when enabled.
   always @(posedge Clock) begin
      if (!PrngEnable) gen <= {3'b000, PrngSeed, 3'b000};
      else             gen <= gen * 16'd5 + 16'd1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      logic [15:0] exp_val [4];
      logic        exp_who [4];
      logic [15:0] prev_rand;
      logic        prev_ack;
      int          n;

      exp_val[0] = 16'h001F; exp_who[0] = 1'b0;
      exp_val[1] = 16'h4C4B; exp_who[1] = 1'b1;
      exp_val[2] = 16'h43B7; exp_who[2] = 1'b0;
      exp_val[3] = 16'h5263; exp_who[3] = 1'b1;

      // Reset values and the single SEED cycle after release.
      tick();
      tick();
      check("rst_enable", PrngEnable, 1'b0);
      check("rst_busy", Busy, 1'b1);
      check("rst_rand", RandOut, 16'h0000);
      check("rst_acks", {Ack0, Ack1}, 2'b00);
      check("rst_seed", PrngSeed, 10'h000);
      Reset = 1'b0;
      check("seed_enable", PrngEnable, 1'b0);
      check("seed_busy", Busy, 1'b1);
      tick();
      check("run_enable", PrngEnable, 1'b1);
      check("run_busy", Busy, 1'b0);
      check("run_gen", gen, 16'h0000);
      tick();
      check("run_enable_hold", PrngEnable, 1'b1);
      check("run_rand", RandOut, 16'h0000);
      $display("reset: enable=%b busy=%b rand=%h", PrngEnable, Busy, RandOut);

`ifndef PRNG_ARBITER_SEED_MIX_EN
      // Reseed with 1, then serve Req0 with a 3-cycle stir.
      SeedIn = 10'h001;
      SeedLoad = 1'b1;
      tick();
      SeedLoad = 1'b0;
      check("t2_seed", PrngSeed, 10'h001);
      check("t2_seed_enable", PrngEnable, 1'b0);
      Req0 = 1'b1;
      tick();
      check("t2_gen0", gen, 16'h0008);
      check("t2_busy_run", Busy, 1'b0);
      tick();
      check("t2_busy_stir", Busy, 1'b1);
      check("t2_gen1", gen, 16'h0029);
      tick();
      check("t2_gen2", gen, 16'h00CE);
      tick();
      check("t2_gen3", gen, 16'h0407);
      check("t2_ack_early", Ack0, 1'b0);
      tick();
      check("t2_ack0", Ack0, 1'b1);
      check("t2_ack1", Ack1, 1'b0);
      check("t2_rand", RandOut, 16'h0407);
      $display("txn: ack0=%b ack1=%b rand=%h", Ack0, Ack1, RandOut);
      Req0 = 1'b0;
      tick();
      check("t2_ack_width", Ack0, 1'b0);
      check("t2_idle_busy", Busy, 1'b0);
`endif

      // Both requesters held: alternating service starting with requester 0.
      do_reset();
      tick();
      Req0 = 1'b1;
      Req1 = 1'b1;
      n = 0;
      prev_rand = RandOut;
      prev_ack = 1'b0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         tick();
         check("t3_no_both", Ack0 & Ack1, 1'b0);
         if (prev_ack) check("t3_ack_width", {Ack0, Ack1}, 2'b00);
         prev_ack = Ack0 | Ack1;
         if (Ack0 || Ack1) begin
            check("t3_grantee", Ack1, exp_who[n]);
            check("t3_rand", RandOut, exp_val[n]);
            check("t3_rand_differs", RandOut != prev_rand, 1'b1);
            $display("txn: ack0=%b ack1=%b rand=%h", Ack0, Ack1, RandOut);
            prev_rand = RandOut;
            if (n == 3) Req1 = 1'b0;
            n++;
         end
      end
      check("t3_ack_count", n, 4);

      // Req0 is granted again; reset lands in the middle of that stir.
      tick();
      check("t5_busy_stir", Busy, 1'b1);
      Req0 = 1'b0;
      tick();
      #3;
      Reset = 1'b1;
      #1;
      check("t5_async_busy", Busy, 1'b1);
      check("t5_async_enable", PrngEnable, 1'b0);
      check("t5_async_rand", RandOut, 16'h0000);
      check("t5_async_acks", {Ack0, Ack1}, 2'b00);
      check("t5_async_seed", PrngSeed, 10'h000);
      tick();
      check("t5_no_ack_a", {Ack0, Ack1}, 2'b00);
      tick();
      check("t5_no_ack_b", {Ack0, Ack1}, 2'b00);
      Reset = 1'b0;
      check("t5_seed_enable", PrngEnable, 1'b0);
      tick();
      check("t5_run_enable", PrngEnable, 1'b1);
      $display("reset mid-stir: enable=%b busy=%b rand=%h", PrngEnable, Busy, RandOut);

`ifndef PRNG_ARBITER_SEED_MIX_EN
      // Reseed pulsed during a stir while Req1 waits: reseed precedes Req1's service.
      Req0 = 1'b1;
      Req1 = 1'b1;
      tick();
      SeedIn = 10'h155;
      SeedLoad = 1'b1;
      tick();
      SeedLoad = 1'b0;
      tick();
      tick();
      check("t4_ack0", Ack0, 1'b1);
      check("t4_ack1_early", Ack1, 1'b0);
      check("t4_rand0", RandOut, 16'h001F);
      $display("txn: ack0=%b ack1=%b rand=%h", Ack0, Ack1, RandOut);
      Req0 = 1'b0;
      tick();
      check("t4_seed_busy", Busy, 1'b1);
      check("t4_seed_enable", PrngEnable, 1'b0);
      check("t4_seed_val", PrngSeed, 10'h155);
      check("t4_seed_ack1", Ack1, 1'b0);
      tick();
      check("t4_gen_seeded", gen, 16'h0AA8);
      check("t4_run_ack1", Ack1, 1'b0);
      tick();
      tick();
      tick();
      check("t4_stir_ack1", Ack1, 1'b0);
      tick();
      check("t4_ack1", Ack1, 1'b1);
      check("t4_rand1", RandOut, 16'h3427);
      $display("txn: ack0=%b ack1=%b rand=%h", Ack0, Ack1, RandOut);
      Req1 = 1'b0;
`else
      // Seed mixing: SeedIn 3FF captured while the counter reads 5.
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      SeedIn = 10'h3FF;
      SeedLoad = 1'b1;
      tick();
      SeedLoad = 1'b0;
      check("mix_seed", PrngSeed, 10'h3FA);
      check("mix_enable", PrngEnable, 1'b0);
      $display("mix: seed=%h", PrngSeed);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prng_arbiter.md
Name: prng_arbiter

Overview:
- Controller and arbiter for the 16-bit LCG pseudo-random generator (state' = state*5+1 mod 2^16; 10-bit seed loaded into state[12:3] while its Enable is low).
- Owns the generator's Enable and Seed inputs and reads back its 16-bit state (Disp3..Disp0 concatenated).
- Seeds the generator, then keeps it free-running.
- Shares it between two requesters with round-robin arbitration. Each grant gets a fresh 16-bit value after a configurable stir delay.

Parameters:
- STIR_CYCLES, 3, number of enabled generator cycles between a grant and the value capture; legal range 1..15.
- RESET_SEED, 10'h000, seed loaded automatically after reset.

Ports:
- Clock  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- SeedIn  input  10  new seed value
- SeedLoad  input  1  one-cycle pulse requesting a reseed with SeedIn
- Req0  input  1  requester 0 wants a value; level, held until Ack0
- Req1  input  1  requester 1 wants a value; level, held until Ack1
- Ack0  output  1  one-cycle pulse; RandOut valid for requester 0
- Ack1  output  1  one-cycle pulse; RandOut valid for requester 1
- RandOut  output  16  captured random value; holds until next capture
- Busy  output  1  high in SEED and STIR states
- PrngEnable  output  1  drives the generator's Enable
- PrngSeed  output  10  drives the generator's Seed
- PrngState  input  16  generator state {Disp3,Disp2,Disp1,Disp0}

Behaviour:
- Reset (asynchronous):
  - State=SEED, SeedReg=RESET_SEED.
  - PrngEnable=0, PrngSeed=RESET_SEED, RandOut=0, Ack0=Ack1=0, Busy=1.
  - RR pointer=0, which means requester 0 has priority. PendSeed=0.
- All outputs are registered. PrngSeed always equals SeedReg.
- SEED:
  - Lasts exactly 1 cycle with PrngEnable=0; the generator loads {3'b0,SeedReg,3'b0} at the exiting edge.
  - Next state: RUN. Reqs are ignored in SEED.
- RUN:
  - PrngEnable=1, so the generator advances every cycle.
  - Priority 1: if SeedLoad or PendSeed, capture SeedReg<=SeedIn (or the pended value), clear PendSeed, go to SEED.
  - Priority 2: if any eligible Req, grant and go to STIR. Load counter=STIR_CYCLES-1 and record the grantee.
  - With both Reqs eligible, grant the requester indicated by the RR pointer. The pointer toggles to the other requester after each Ack.
  - A requester whose Ack is high this cycle is not eligible this cycle. This prevents double service when Req drops late.
- STIR:
  - PrngEnable=1. The counter decrements each cycle.
  - On the edge leaving the cycle where counter==0: RandOut<=PrngState (value present in that cycle), assert the grantee's Ack for exactly 1 cycle, go to RUN.
  - Latency: Ack rises STIR_CYCLES edges after the edge that sampled the granting Req.
- SeedLoad while in SEED or STIR:
  - Latch SeedIn into PendSeedVal and set PendSeed. A later pulse overwrites the pended value.
  - Applied on the first RUN cycle, and takes priority over pending Reqs.
- Req dropped during STIR: the service completes anyway. Ack pulses and RandOut updates; the requester may ignore it.
- Req still high the cycle after its Ack: treated as a new request, subject to the RR pointer.
- Ack0 and Ack1 are never high together.
- Reset mid-STIR: the grant is abandoned, no Ack is issued, and the block reseeds with RESET_SEED.

Optional Feature:
- Macro: PRNG_ARBITER_SEED_MIX_EN.
- Defined:
  - A 10-bit free-running counter runs from reset (reset value 0).
  - Any seed captured from SeedIn (direct or pended) is stored as SeedIn XOR counter value at the capture edge. This adds timing entropy.
  - RESET_SEED is not mixed.
- Undefined: the counter is absent and SeedIn is stored unmodified.

Test Plan:
- Reset release, RESET_SEED=0, no Reqs -> exactly one SEED cycle with PrngEnable=0, PrngSeed=0, then PrngEnable=1 held; Busy 1 then 0; RandOut=16'h0000.
- SeedLoad with SeedIn=10'h001 (mix off); Req0 high in the first RUN cycle after SEED; STIR_CYCLES=3 -> generator states seen are 0x0008, 0x0029, 0x00CE, 0x0407. Ack0 pulses 3 edges after the grant edge with RandOut=16'h0407; Ack1 stays 0.
- Req0 and Req1 held high continuously, pointer=0 -> Acks alternate 0,1,0,1. Each Ack is 1 cycle wide, no cycle has both Acks high, and successive RandOut values differ.
- SeedLoad with SeedIn=10'h155 pulsed mid-STIR while Req1 is pending -> the current Ack completes, the next cycle enters SEED with PrngSeed=10'h155, and Req1 is served only after the reseed.
- Reset asserted mid-STIR -> no Ack; all outputs return to reset values asynchronously (before the next Clock edge); SEED follows reset release.
- With PRNG_ARBITER_SEED_MIX_EN defined: SeedLoad with SeedIn=10'h3FF at counter value 10'h005 -> PrngSeed=10'h3FA.
